wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Two-master, one-slave Wishbone arbiter in front of the FPGA-side SoC Wishbone slave port. Master 0 is the AHB-to-FPGA bridge of the cell macro, and master 1 is a local fabric master, such as a future DMA engine. The block grants the bus round-robin per complete cycle and muxes the master signals to the slave. A bus watchdog terminates with ERR any slave access that is not acknowledged in time, so the M4 bridge can never hang.

## Interface
Parameters:
- ADDR_W, 17: address width (byte address, same as the bridge).
- DATA_W, 32: data width; the byte-strobe width is DATA_W/8.
- TIMEOUT, 255: maximum number of wait cycles before a forced ERR; range 1..65535.

Ports:
- WB_CLK  in  1  single clock for the whole block.
- WB_RST  in  1  reset; asynchronous, active-high.
- m0_adr, m1_adr  in  ADDR_W  master address.
- m0_dat_w, m1_dat_w  in  DATA_W  master write data.
- m0_sel, m1_sel  in  DATA_W/8  byte strobes.
- m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb  in  1  master control.
- m0_dat_r, m1_dat_r  out  DATA_W  read data; both are driven from s_dat_r.
- m0_ack, m1_ack, m0_err, m1_err  out  1  cycle termination to the granted master only.
- s_adr, s_dat_w, s_sel, s_we, s_cyc, s_stb  out  (as above)  muxed slave request.
- s_dat_r  in  DATA_W; s_ack, s_err  in  1  slave response.
- gnt  out  2  one-hot registered grant, or 0 when idle.

## Operation
- FSM states:
  - IDLE: gnt=0, s_cyc=0.
  - OWN0 / OWN1: gnt=01 / 10.
  - ABORT: the grant is held, s_cyc=s_stb=0.
- Arbitration from IDLE:
  - Only one mX_cyc=1: go to OWNX.
  - Both requesting: grant the master that was not served last.
  - The `last` register resets to 1, so m0 wins the first tie.
- Holding the grant:
  - OWNX holds while mX_cyc=1; strobes within one cycle (block transfers) keep the grant.
  - The other master's requests are ignored and that master sees ack=err=0.
- Releasing the grant:
  - Triggered when mX_cyc falls.
  - Sets last:=X and returns to IDLE.
  - The new arbitration happens in the IDLE cycle, so there is no back-to-back regrant without one idle cycle.
- Mux while in OWNX:
  - s_* = mX_*.
  - mX_ack = s_ack.
  - mX_err = s_err | timeout_pulse.
- In IDLE and ABORT: all s_cyc/s_stb and all mX_ack/mX_err are 0.
- Watchdog:
  - Counter width is clog2(TIMEOUT+1).
  - Clears when s_stb=0 or (s_ack|s_err)=1; otherwise it increments each cycle s_stb=1.
  - When count==TIMEOUT with no ack: mX_err pulses for 1 cycle and the FSM moves to ABORT.
  - ABORT holds until mX_cyc=0, then sets last:=X and returns to IDLE.
- Simultaneous ack and timeout in the same cycle: the ack wins and no err is issued.
- Reset:
  - Asynchronous return to IDLE: gnt=0, counter=0, last=1.
  - All outputs go low immediately (s_cyc, s_stb, acks, errs).
  - This applies even mid-transaction.

## Timing
- Grant latency: mX_cyc sampled high in IDLE at edge n gives gnt and s_cyc/s_stb at edge n+1.
- Ack path is combinational (s_ack to mX_ack, same cycle); there is no added pipeline on data or ack.
- Worst-case wait for a master is one full opposing cycle plus 1 idle cycle plus 1 grant cycle.
- Timeout ERR is asserted during the cycle in which the counter equals TIMEOUT. That is TIMEOUT+1 cycles after s_stb first rose, with s_ack low throughout.
- gnt, state, counter and last are registers; the muxes are combinational from gnt.
- Outputs after reset: gnt=0, s_cyc=s_stb=s_we=0, s_adr=s_dat_w=s_sel=0, all ack/err=0.

## Test plan
- Single m0 write:
  - Stimulus: m0 writes adr=0x0100, data=0xDEADBEEF, sel=F; the slave acks 2 cycles after s_stb.
  - Required: s_* mirror m0 from edge n+1; m0_ack pulses once; m1_ack=0; gnt returns to 0 after m0_cyc falls.
- Tie arbitration:
  - Stimulus: m0 and m1 assert cyc in the same cycle, 4 times in a row.
  - Required: grant order 0,1,0,1.
- Contention:
  - Stimulus: m1 requests while m0 holds a 3-strobe block read.
  - Required: m1 gets no ack/err until m0 drops cyc; m1 is granted after exactly 1 idle cycle.
- Timeout:
  - Stimulus: TIMEOUT=8; the slave never acks a m1 read.
  - Required: m1_err is high for exactly 1 cycle, 9 cycles after s_stb rose; s_cyc is 0 in ABORT; the FSM returns to IDLE when m1_cyc drops.
- Ack versus timeout race:
  - Stimulus: s_ack arrives in the same cycle the counter equals TIMEOUT.
  - Required: ack is delivered, no err, normal release.
- Reset mid-cycle:
  - Stimulus: WB_RST asserted mid-cycle during an m0 transfer, between clock edges.
  - Required: gnt=0 and s_cyc=0 before the next edge. After release, a tie goes to m0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_rr_arbiter
//  Description : Two-master / one-slave Wishbone arbiter. The bus is granted
//                round-robin per complete Wishbone cycle. A watchdog ends any
//                strobe that the slave leaves unanswered for too long.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST,
    // master 0 (AHB bridge)
    input  logic [ADDR_W-1:0]     m0_adr,
    input  logic [DATA_W-1:0]     m0_dat_w,
    input  logic [DATA_W/8-1:0]   m0_sel,
    input  logic                  m0_we,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    output logic [DATA_W-1:0]     m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,
    // master 1 (fabric master)
    input  logic [ADDR_W-1:0]     m1_adr,
    input  logic [DATA_W-1:0]     m1_dat_w,
    input  logic [DATA_W/8-1:0]   m1_sel,
    input  logic                  m1_we,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    output logic [DATA_W-1:0]     m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,
    // slave
    output logic [ADDR_W-1:0]     s_adr,
    output logic [DATA_W-1:0]     s_dat_w,
    output logic [DATA_W/8-1:0]   s_sel,
    output logic                  s_we,
    output logic                  s_cyc,
    output logic                  s_stb,
    input  logic [DATA_W-1:0]     s_dat_r,
    input  logic                  s_ack,
    input  logic                  s_err,
    // grant
    output logic [1:0]            gnt
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               own0;
    logic               own1;
    logic               owner_cyc;
    logic               timeout_pulse;

    assign own0      = (state_q == OWN0);
    assign own1      = (state_q == OWN1);
    // gnt stays valid through ABORT, so it identifies the owner in both states
    assign owner_cyc = gnt_q[1] ? m1_cyc : m0_cyc;
    assign gnt       = gnt_q;

    // Route the owning master's request to the slave; everything is low otherwise
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        if (own0) begin
            s_adr   = m0_adr;
            s_dat_w = m0_dat_w;
            s_sel   = m0_sel;
            s_we    = m0_we;
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
        end else if (own1) begin
            s_adr   = m1_adr;
            s_dat_w = m1_dat_w;
            s_sel   = m1_sel;
            s_we    = m1_we;
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
        end
    end

    // A slave answer in the final watchdog cycle wins over the forced error
    assign timeout_pulse = s_stb && !s_ack && !s_err && (cnt_q == CNT_MAX);

    assign m0_ack   = own0 && s_ack;
    assign m1_ack   = own1 && s_ack;
    assign m0_err   = own0 && (s_err || timeout_pulse);
    assign m1_err   = own1 && (s_err || timeout_pulse);
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // Next-state logic: arbitration, release, watchdog abort
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = (s_stb && !s_ack && !s_err) ? (cnt_q + CNT_W'(1)) : '0;
        case (state_q)
            IDLE: begin
                // on a tie the master not served last wins
                if (m0_cyc && (!m1_cyc || last_q)) begin
                    state_d = OWN0;
                    gnt_d   = 2'b01;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                    gnt_d   = 2'b10;
                end
            end
            OWN0, OWN1: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                end else if (timeout_pulse) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State registers; reset drops the grant at once, even mid-transfer
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_rr_arbiter
//  Description : Scoreboard bench for wb_rr_arbiter: master BFMs, a slave
//                responder with planned latencies, and a decoupled monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int TMO = 8;

    typedef struct {
        int          m;
        logic [16:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        int          lat;    // cycle index (0 = first strobe cycle) of the slave answer
        logic        serr;   // slave answers with err instead of ack
        logic [31:0] rdat;
    } xfer_t;

    logic        WB_CLK = 1'b0;
    logic        WB_RST = 1'b1;
    logic [16:0] ma_adr [2];
    logic [31:0] ma_dat [2];
    logic [3:0]  ma_sel [2];
    logic        ma_we  [2];
    logic        ma_cyc [2];
    logic        ma_stb [2];
    logic [31:0] m0_dat_r, m1_dat_r;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [16:0] s_adr;
    logic [31:0] s_dat_w;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err;
    logic [1:0]  gnt;

    wb_rr_arbiter #(.ADDR_W(17), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST),
        .m0_adr(ma_adr[0]), .m0_dat_w(ma_dat[0]), .m0_sel(ma_sel[0]), .m0_we(ma_we[0]),
        .m0_cyc(ma_cyc[0]), .m0_stb(ma_stb[0]), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(ma_adr[1]), .m1_dat_w(ma_dat[1]), .m1_sel(ma_sel[1]), .m1_we(ma_we[1]),
        .m1_cyc(ma_cyc[1]), .m1_stb(ma_stb[1]), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .gnt(gnt)
    );

    always #5 WB_CLK = ~WB_CLK;

    int    n_checks = 0;
    int    n_err    = 0;
    xfer_t exp_q[$];
    xfer_t slv_q[$];
    xfer_t lst0[$];
    xfer_t lst1[$];
    bit    model_last = 1'b1;   // index of the master served most recently
    bit    mon_en = 1'b0;
    bit    slv_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit term(input int m);
        return (m == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err);
    endfunction

    function automatic xfer_t mk(input int m, input int lat, input bit serr);
        xfer_t x;
        x.m    = m;
        x.adr  = 17'($urandom);
        x.wdat = $urandom;
        x.sel  = 4'($urandom);
        x.we   = 1'($urandom);
        x.lat  = lat;
        x.serr = serr;
        x.rdat = $urandom;
        return x;
    endfunction

    function automatic bit ends_in_err(input xfer_t x);
        return x.serr || (x.lat > TMO);
    endfunction

    // random block of 1..n strobes; the master gives up after the first error
    task automatic mk_list(input int m, input int n);
        xfer_t x;
        int    r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      x = mk(m, $urandom_range(0, 3), 1'b0);
            else if (r < 80) x = mk(m, TMO, 1'b0);
            else if (r < 90) x = mk(m, TMO + 4, 1'b0);
            else             x = mk(m, $urandom_range(0, 3), 1'b1);
            if (m == 0) lst0.push_back(x); else lst1.push_back(x);
            if (ends_in_err(x)) break;
        end
    endtask

    // Master BFM: one Wishbone cycle containing every strobe queued for master m
    task automatic run_master(input int m, input int dly);
        xfer_t x;
        int    w;
        int    n;
        bit    tmo_last;
        n = (m == 0) ? lst0.size() : lst1.size();
        tmo_last = 1'b0;
        repeat (dly) @(posedge WB_CLK);
        @(posedge WB_CLK); #1;
        for (int i = 0; i < n; i++) begin
            if (m == 0) x = lst0.pop_front(); else x = lst1.pop_front();
            ma_adr[m] = x.adr; ma_dat[m] = x.wdat; ma_sel[m] = x.sel; ma_we[m] = x.we;
            ma_cyc[m] = 1'b1;  ma_stb[m] = 1'b1;
            w = 0;
            do begin
                @(negedge WB_CLK);
                w++;
            end while (!term(m) && w < 400);
            if (!term(m)) check($sformatf("m%0d_wait_bound", m), 64'(w), 64'(0));
            tmo_last = (x.lat > TMO);
            @(posedge WB_CLK); #1;
        end
        // after a watchdog error the master may linger; the arbiter must keep the slave quiet
        if (tmo_last) repeat ($urandom_range(0, 3)) begin @(posedge WB_CLK); #1; end
        ma_cyc[m] = 1'b0; ma_stb[m] = 1'b0; ma_we[m] = 1'b0;
    endtask

    // Reference model: complete cycles are served in request order, ties go to the
    // master not served last; every strobe of a cycle is answered before the next cycle
    task automatic episode(input int req, input int d0, input int d1);
        int first, second;
        second = -1;
        if (req == 1)      first = 0;
        else if (req == 2) first = 1;
        else begin
            if (d0 < d1)      first = 0;
            else if (d1 < d0) first = 1;
            else              first = model_last ? 0 : 1;
            second = 1 - first;
        end
        foreach (lst0[i]) if (first == 0) begin exp_q.push_back(lst0[i]); slv_q.push_back(lst0[i]); end
        foreach (lst1[i]) if (first == 1 || second == 1) begin exp_q.push_back(lst1[i]); slv_q.push_back(lst1[i]); end
        if (second == 0) foreach (lst0[i]) begin exp_q.push_back(lst0[i]); slv_q.push_back(lst0[i]); end
        model_last = (second >= 0) ? second[0] : first[0];
        fork
            begin if ((req & 1) != 0) run_master(0, d0); end
            begin if ((req & 2) != 0) run_master(1, d1); end
        join
        repeat ($urandom_range(2, 4)) @(posedge WB_CLK);
    endtask

    // Slave responder: answers each strobe after its planned number of cycles
    xfer_t slv_cur;
    int    slv_age = 0;
    bit    slv_act = 1'b0;
    bit    slv_hit;
    initial begin
        s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
        forever begin
            @(posedge WB_CLK); #2;
            if (WB_RST || !slv_en || !s_stb) begin
                slv_act = 1'b0; s_ack = 1'b0; s_err = 1'b0;
            end else begin
                if (!slv_act) begin
                    if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
                    else slv_cur = mk(0, 1000, 1'b0);
                    slv_act = 1'b1;
                    slv_age = 0;
                end else slv_age++;
                slv_hit = (slv_age == slv_cur.lat);
                s_ack   = slv_hit && !slv_cur.serr;
                s_err   = slv_hit && slv_cur.serr;
                s_dat_r = slv_hit ? slv_cur.rdat : $urandom;
                if (slv_hit) slv_act = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every termination and watches grant/abort timing
    xfer_t mon_e;
    int    mon_age = 0;
    bit    mon_act = 1'b0;
    bit    pend_grant = 1'b0;
    bit    abort_on = 1'b0;
    bit    abort_rel = 1'b0;
    logic [1:0] abort_gnt = 2'b00;
    bit    t0, t1, ackd;
    initial begin
        forever begin
            @(negedge WB_CLK);
            t0 = m0_ack || m0_err;
            t1 = m1_ack || m1_err;
            if (s_stb) begin
                mon_age = mon_act ? mon_age + 1 : 0;
                mon_act = !(s_ack || s_err || t0 || t1);
            end else mon_act = 1'b0;
            if (WB_RST || !mon_en) begin
                pend_grant = 1'b0; abort_on = 1'b0;
            end else begin
                if (pend_grant) check("grant_latency_nonzero", 64'(gnt != 2'b00), 64'(1));
                pend_grant = (gnt == 2'b00) && (ma_cyc[0] || ma_cyc[1]);
                if (abort_on) begin
                    if (abort_rel) begin
                        check("abort_release_gnt", 64'(gnt), 64'(0));
                        abort_on = 1'b0;
                    end else begin
                        check("abort_hold", {gnt, s_cyc, s_stb, t0, t1}, {abort_gnt, 4'b0000});
                        abort_rel = !(abort_gnt[1] ? ma_cyc[1] : ma_cyc[0]);
                    end
                end
                if (t0 || t1) begin
                    if (t0 && t1) check("both_terminated", 64'(1), 64'(0));
                    else if (exp_q.size() == 0) check("unexpected_termination", 64'(1), 64'(0));
                    else begin
                        mon_e = exp_q.pop_front();
                        ackd  = t0 ? m0_ack : m1_ack;
                        check("term_master", 64'(t1), 64'(mon_e.m));
                        check("term_gnt", 64'(gnt), (mon_e.m == 1) ? 64'(2) : 64'(1));
                        check("term_kind_ack", 64'(ackd), 64'(!ends_in_err(mon_e)));
                        check("term_slave_req", {s_cyc, s_stb, s_we, s_sel, s_adr},
                              {1'b1, 1'b1, mon_e.we, mon_e.sel, mon_e.adr});
                        if (mon_e.we) check("term_wdata", 64'(s_dat_w), 64'(mon_e.wdat));
                        if (!mon_e.we && ackd)
                            check("term_rdata", 64'(t0 ? m0_dat_r : m1_dat_r), 64'(mon_e.rdat));
                        if (mon_e.lat > TMO) begin
                            check("timeout_cycle_index", 64'(mon_age), 64'(TMO));
                            abort_on  = 1'b1;
                            abort_rel = 1'b0;
                            abort_gnt = (mon_e.m == 1) ? 2'b10 : 2'b01;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    xfer_t x;
    int    req;
    initial begin
        for (int i = 0; i < 2; i++) begin
            ma_adr[i] = '0; ma_dat[i] = '0; ma_sel[i] = '0;
            ma_we[i] = 1'b0; ma_cyc[i] = 1'b0; ma_stb[i] = 1'b0;
        end
        repeat (3) @(posedge WB_CLK);
        #1 WB_RST = 1'b0;
        @(negedge WB_CLK);
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_s_ctrl", {s_cyc, s_stb, s_we}, 64'(0));
        check("rst_s_adr", 64'(s_adr), 64'(0));
        check("rst_s_dat_w", 64'(s_dat_w), 64'(0));
        check("rst_s_sel", 64'(s_sel), 64'(0));
        check("rst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 64'(0));
        mon_en = 1'b1;

        // simultaneous requests, four times
        repeat (4) begin
            lst0.push_back(mk(0, 1, 1'b0));
            lst1.push_back(mk(1, 1, 1'b0));
            episode(3, 0, 0);
        end
        // single m0 write, slave answers two cycles into the strobe
        x = mk(0, 2, 1'b0);
        x.adr = 17'h00100; x.wdat = 32'hDEADBEEF; x.sel = 4'hF; x.we = 1'b1;
        lst0.push_back(x);
        episode(1, 0, 0);
        // m1 arrives while m0 runs a 3-strobe block read
        for (int i = 0; i < 3; i++) begin
            x = mk(0, $urandom_range(0, 2), 1'b0);
            x.we = 1'b0;
            lst0.push_back(x);
        end
        lst1.push_back(mk(1, 1, 1'b0));
        episode(3, 0, 2);
        // m1 read that the slave never answers
        x = mk(1, TMO + 12, 1'b0);
        x.we = 1'b0;
        lst1.push_back(x);
        episode(2, 0, 0);
        // answer lands exactly in the last watchdog cycle
        x = mk(0, TMO, 1'b0);
        x.we = 1'b0;
        lst0.push_back(x);
        episode(1, 0, 0);
        // randomized traffic
        repeat (40) begin
            req = $urandom_range(1, 3);
            if ((req & 1) != 0) mk_list(0, $urandom_range(1, 3));
            if ((req & 2) != 0) mk_list(1, $urandom_range(1, 3));
            episode(req, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        repeat (4) @(posedge WB_CLK);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        check("slave_plan_drained", 64'(slv_q.size()), 64'(0));

        // asynchronous reset in the middle of an m0 transfer
        mon_en = 1'b0;
        slv_en = 1'b0;
        @(posedge WB_CLK); #1;
        ma_adr[0] = 17'h1234; ma_cyc[0] = 1'b1; ma_stb[0] = 1'b1;
        repeat (2) @(posedge WB_CLK);
        #1 check("pre_reset_gnt", 64'(gnt), 64'(1));
        #2 WB_RST = 1'b1;
        #1;
        check("midrst_gnt", 64'(gnt), 64'(0));
        check("midrst_s_cyc_stb", {s_cyc, s_stb}, 64'(0));
        check("midrst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 64'(0));
        ma_cyc[0] = 1'b0; ma_stb[0] = 1'b0;
        @(posedge WB_CLK); #1;
        WB_RST = 1'b0;
        ma_cyc[0] = 1'b1; ma_cyc[1] = 1'b1;
        @(posedge WB_CLK); #1;
        check("post_reset_tie_gnt", 64'(gnt), 64'(1));
        ma_cyc[0] = 1'b0; ma_cyc[1] = 1'b0;
        repeat (3) @(posedge WB_CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
